// File: rtl/guess_game_controller.sv
// Guessing-game sequencer: draws a secret, scores guesses taken on submit
// release, and tracks trial usage until win or loss.
module guess_game_controller #(
   parameter int unsigned W     = 4,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             submit,
   input  logic [W-1:0]     guess,
   input  logic [CNT_W-1:0] trials,
   input  logic             force_en,
   input  logic [W-1:0]     force_val,
   output logic [1:0]       state,
   output logic             hint_high,
   output logic             hint_low,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] left,
   output logic [W-1:0]     reveal
);

   localparam int unsigned LFSR_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      WIN  = 2'b10,
      LOSE = 2'b11
   } state_t;

   state_t             cur;
   logic [LFSR_W-1:0]  lfsr;
   logic               submit_q;
   logic [W-1:0]       secret;
   logic [CNT_W-1:0]   trials_lat;

   logic               rel;
   logic               lfsr_fb;
   logic [CNT_W-1:0]   count_inc;
   logic [CNT_W-1:0]   trials_eff;
   logic [W-1:0]       rand_val;

   // x^8+x^6+x^5+x^4+1; a nonzero seed keeps it out of the all-zero lockup
   assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign rel        = submit_q & ~submit;
   assign count_inc  = count + CNT_W'(1);
   assign trials_eff = (trials == '0) ? CNT_W'(1) : trials;
   assign rand_val   = W'(lfsr);
   assign state      = cur;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur        <= IDLE;
         lfsr       <= LFSR_W'(1);
         submit_q   <= 1'b0;
         secret     <= '0;
         trials_lat <= '0;
         count      <= '0;
         left       <= '0;
         hint_high  <= 1'b0;
         hint_low   <= 1'b0;
         reveal     <= '0;
      end else begin
         lfsr     <= {lfsr[LFSR_W-2:0], lfsr_fb};
         submit_q <= submit;
         case (cur)
            IDLE, WIN, LOSE: begin
               // new game; a coincident release is discarded
               if (start) begin
                  secret     <= force_en ? force_val : rand_val;
                  trials_lat <= trials_eff;
                  count      <= '0;
                  left       <= trials_eff;
                  hint_high  <= 1'b0;
                  hint_low   <= 1'b0;
                  reveal     <= '0;
                  cur        <= PLAY;
               end
            end
            PLAY: begin
               if (rel) begin
                  count <= count_inc;
                  left  <= trials_lat - count_inc;
                  // win check precedes exhaustion so a last-trial hit still wins
                  if (guess == secret) begin
                     hint_high <= 1'b0;
                     hint_low  <= 1'b0;
                     reveal    <= secret;
                     cur       <= WIN;
                  end else if (count_inc == trials_lat) begin
                     hint_high <= 1'b0;
                     hint_low  <= 1'b0;
                     reveal    <= secret;
                     cur       <= LOSE;
                  end else begin
                     hint_high <= (guess > secret);
                     hint_low  <= (guess < secret);
                  end
               end
            end
            default: cur <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_guess_game_controller.sv
// Directed scoreboard bench for guess_game_controller: expectations are queued
// as stimulus is applied and checked one cycle later.
module tb_guess_game_controller;

   logic       clk;
   logic       rst;
   logic       start;
   logic       submit;
   logic [3:0] guess;
   logic [3:0] trials;
   logic       force_en;
   logic [3:0] force_val;
   logic [1:0] state;
   logic       hint_high;
   logic       hint_low;
   logic [3:0] count;
   logic [3:0] left;
   logic [3:0] reveal;

   typedef struct {
      string      tag;
      logic [1:0] st;
      logic       hh;
      logic       hl;
      logic [3:0] cnt;
      logic [3:0] lft;
      logic [3:0] rev;
   } exp_t;

   exp_t exp_q[$];
   int   tests;
   int   fails;
   logic [7:0] m_lfsr;
   logic [3:0] exp_secret;

   guess_game_controller #(.W(4), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .submit    (submit),
      .guess     (guess),
      .trials    (trials),
      .force_en  (force_en),
      .force_val (force_val),
      .state     (state),
      .hint_high (hint_high),
      .hint_low  (hint_low),
      .count     (count),
      .left      (left),
      .reveal    (reveal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference LFSR, x^8+x^6+x^5+x^4+1 shifting left every cycle
   always @(posedge clk) begin
      if (rst) m_lfsr <= 8'h01;
      else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   task automatic expect_out(input string tag, input logic [1:0] st, input logic hh,
                             input logic hl, input logic [3:0] cnt, input logic [3:0] lft,
                             input logic [3:0] rev);
      exp_t e;
      e.tag = tag; e.st = st; e.hh = hh; e.hl = hl; e.cnt = cnt; e.lft = lft; e.rev = rev;
      exp_q.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      logic [17:0] obs;
      logic [17:0] want;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e    = exp_q.pop_front();
         obs  = {state, hint_high, hint_low, count, left, reveal};
         want = {e.st, e.hh, e.hl, e.cnt, e.lft, e.rev};
         tests++;
         assert (obs === want)
         else begin
            fails++;
            $error("FAIL %s: observed st=%b hh=%b hl=%b cnt=%0d left=%0d rev=%0d expected st=%b hh=%b hl=%b cnt=%0d left=%0d rev=%0d",
                   e.tag, state, hint_high, hint_low, count, left, reveal,
                   e.st, e.hh, e.hl, e.cnt, e.lft, e.rev);
         end
      end
   endtask

   // press then release; the guess is sampled on the release cycle
   task automatic press_release(input logic [3:0] g, input string tag, input logic [1:0] st,
                                input logic hh, input logic hl, input logic [3:0] cnt,
                                input logic [3:0] lft, input logic [3:0] rev);
      submit = 1'b1;
      cycle();
      submit = 1'b0;
      guess  = g;
      expect_out(tag, st, hh, hl, cnt, lft, rev);
      cycle();
   endtask

   task automatic new_game(input logic fe, input logic [3:0] fv, input logic [3:0] tr,
                           input logic [3:0] lft, input string tag);
      force_en  = fe;
      force_val = fv;
      trials    = tr;
      start     = 1'b1;
      expect_out(tag, 2'b01, 1'b0, 1'b0, 4'd0, lft, 4'd0);
      cycle();
      start = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; start = 1'b0; submit = 1'b0; guess = '0;
      trials = '0; force_en = 1'b0; force_val = '0;

      // reset with submit toggling; last reset cycle leaves submit high
      submit = 1'b1;
      expect_out("reset_a", 2'b00, 0, 0, 0, 0, 0);
      cycle();
      submit = 1'b0;
      expect_out("reset_b", 2'b00, 0, 0, 0, 0, 0);
      cycle();
      submit = 1'b1;
      cycle();
      rst = 1'b0;
      submit = 1'b0;
      expect_out("idle_release", 2'b00, 0, 0, 0, 0, 0);
      cycle();

      // win game
      new_game(1'b1, 4'd9, 4'd5, 4'd5, "win_start");
      press_release(4'd3,  "win_g1", 2'b01, 0, 1, 4'd1, 4'd4, 4'd0);
      press_release(4'd12, "win_g2", 2'b01, 1, 0, 4'd2, 4'd3, 4'd0);
      press_release(4'd9,  "win_g3", 2'b10, 0, 0, 4'd3, 4'd2, 4'd9);
      press_release(4'd1,  "win_hold", 2'b10, 0, 0, 4'd3, 4'd2, 4'd9);

      // lose game
      new_game(1'b1, 4'd4, 4'd3, 4'd3, "lose_start");
      press_release(4'd1, "lose_g1", 2'b01, 0, 1, 4'd1, 4'd2, 4'd0);
      press_release(4'd2, "lose_g2", 2'b01, 0, 1, 4'd2, 4'd1, 4'd0);
      press_release(4'd3, "lose_g3", 2'b11, 0, 0, 4'd3, 4'd0, 4'd4);
      press_release(4'd4, "lose_hold", 2'b11, 0, 0, 4'd3, 4'd0, 4'd4);

      // zero trial limit behaves as one
      new_game(1'b1, 4'd7, 4'd0, 4'd1, "t0_start");
      press_release(4'd2, "t0_lose", 2'b11, 0, 0, 4'd1, 4'd0, 4'd7);

      // correct guess on last trial wins
      new_game(1'b1, 4'd5, 4'd2, 4'd2, "last_start");
      press_release(4'd0, "last_g1", 2'b01, 0, 1, 4'd1, 4'd1, 4'd0);
      press_release(4'd5, "last_win", 2'b10, 0, 0, 4'd2, 4'd0, 4'd5);

      // start held high into WIN restarts, and has no effect once in PLAY
      force_en = 1'b1; force_val = 4'd1; trials = 4'd2; start = 1'b1;
      expect_out("held_restart", 2'b01, 0, 0, 4'd0, 4'd2, 4'd0);
      cycle();
      trials = 4'd9;
      expect_out("held_in_play", 2'b01, 0, 0, 4'd0, 4'd2, 4'd0);
      cycle();
      start = 1'b0;

      // start + release in IDLE: start wins
      rst = 1'b1;
      expect_out("rst_to_idle", 2'b00, 0, 0, 0, 0, 0);
      cycle();
      rst = 1'b0;
      submit = 1'b1;
      cycle();
      submit = 1'b0; guess = 4'd6;
      force_en = 1'b1; force_val = 4'd6; trials = 4'd4; start = 1'b1;
      expect_out("idle_start_rel", 2'b01, 0, 0, 4'd0, 4'd4, 4'd0);
      cycle();

      // start + release in PLAY: guess processed
      submit = 1'b1;
      cycle();
      submit = 1'b0; guess = 4'd8;
      expect_out("play_start_rel", 2'b01, 1, 0, 4'd1, 4'd3, 4'd0);
      cycle();
      start = 1'b0;

      // submit held low: a single release
      submit = 1'b1;
      cycle();
      submit = 1'b0; guess = 4'd2;
      for (int i = 0; i < 20; i++) begin
         expect_out("held_low", 2'b01, 0, 1, 4'd2, 4'd2, 4'd0);
         cycle();
      end

      // reset mid-game at count=2
      rst = 1'b1;
      expect_out("mid_rst", 2'b00, 0, 0, 0, 0, 0);
      cycle();
      rst = 1'b0;
      cycle();
      cycle();
      cycle();

      // LFSR-drawn secret
      exp_secret = m_lfsr[3:0];
      new_game(1'b0, 4'd15, 4'd3, 4'd3, "lfsr_start");
      press_release(exp_secret, "lfsr_win", 2'b10, 0, 0, 4'd1, 4'd2, exp_secret);

      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
